// File: rtl/ram_dump_uart_tx.sv
// Reads WORDS 16-bit words from a synchronous RAM starting at address 0 and
// streams each one out as two 8N1 UART frames, high byte first.
module ram_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_ram_read,
    input  logic [15:0] data_from_ram,
    output logic [5:0]  address_to_ram,
    output logic        read_enable_to_ram,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int          BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  LAST_ADDR = 6'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t              state_reg;
    logic                en_prev_reg;
    logic [BAUD_W-1:0]   baud_cnt_reg;
    logic [2:0]          bit_cnt_reg;
    logic                low_byte_reg;
    logic [15:0]         shift_reg;
    logic [5:0]          addr_reg;
    logic                rd_en_reg;
    logic                tx_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                bit_done;

    assign bit_done           = (baud_cnt_reg == LAST_BAUD);
    assign address_to_ram     = addr_reg;
    assign read_enable_to_ram = rd_en_reg;
    assign tx                 = tx_reg;
    assign busy               = busy_reg;
    assign done               = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            en_prev_reg  <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            low_byte_reg <= 1'b0;
            shift_reg    <= '0;
            addr_reg     <= '0;
            rd_en_reg    <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            en_prev_reg <= enable_ram_read;
            rd_en_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Only a 0->1 transition starts a dump; a held level does not.
                    if (enable_ram_read && !en_prev_reg) begin
                        state_reg <= FETCH;
                        addr_reg  <= '0;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    shift_reg    <= data_from_ram;
                    low_byte_reg <= 1'b0;
                    baud_cnt_reg <= '0;
                    tx_reg       <= 1'b0;
                    state_reg    <= START;
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt_reg     <= '0;
                        bit_cnt_reg      <= '0;
                        tx_reg           <= shift_reg[8];
                        shift_reg[15:8]  <= {1'b0, shift_reg[15:9]};
                        state_reg        <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg          <= shift_reg[8];
                            shift_reg[15:8] <= {1'b0, shift_reg[15:9]};
                            bit_cnt_reg     <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        if (!low_byte_reg) begin
                            // Move the low byte into the transmit lane for the second frame.
                            low_byte_reg <= 1'b1;
                            shift_reg    <= {shift_reg[7:0], 8'h00};
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end else if (addr_reg == LAST_ADDR) begin
                            low_byte_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            low_byte_reg <= 1'b0;
                            addr_reg     <= addr_reg + 6'd1;
                            rd_en_reg    <= 1'b1;
                            state_reg    <= FETCH;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (!enable_ram_read) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_uart_tx.sv
// Bench for ram_dump_uart_tx: a timeline model of the dump checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_dump_uart_tx;

    localparam int C  = 4;
    localparam int W  = 4;
    localparam int WB = 64;
    localparam int P  = 2 + 20 * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en_a = 1'b0;
    logic [15:0] q_a;
    logic [5:0]  addr_a;
    logic        rd_a, tx_a, busy_a, done_a;

    logic        rst_b = 1'b1;
    logic        en_b = 1'b0;
    logic [15:0] q_b;
    logic [5:0]  addr_b;
    logic        rd_b, tx_b, busy_b, done_b;

    ram_dump_uart_tx #(.CLKS_PER_BIT(C), .WORDS(W)) dut_a (
        .clk(clk), .reset(rst), .enable_ram_read(en_a), .data_from_ram(q_a),
        .address_to_ram(addr_a), .read_enable_to_ram(rd_a), .tx(tx_a),
        .busy(busy_a), .done(done_a)
    );

    ram_dump_uart_tx #(.CLKS_PER_BIT(C), .WORDS(WB)) dut_b (
        .clk(clk), .reset(rst_b), .enable_ram_read(en_b), .data_from_ram(q_b),
        .address_to_ram(addr_b), .read_enable_to_ram(rd_b), .tx(tx_b),
        .busy(busy_b), .done(done_b)
    );

    logic [15:0] mem_a [W];
    logic [15:0] mem_b [WB];
    logic [7:0]  exp_bytes [8];

    initial begin
        mem_a = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001};
        exp_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h80, 8'h01};
        for (int i = 0; i < WB; i++) mem_b[i] = 16'(i * 257) ^ 16'h5A5A;
    end

    always @(posedge clk) if (rd_a) q_a <= mem_a[addr_a[1:0]];
    always @(posedge clk) if (rd_b) q_b <= mem_b[addr_b];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Timeline model: phase 0 idle, 1 dumping (t = cycles since first fetch), 2 done.
    int         m_phase;
    int         m_t;
    logic       m_prev;
    logic [5:0] m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_t     <= 0;
            m_prev  <= 1'b0;
            m_last  <= '0;
        end else begin
            m_prev <= en_a;
            case (m_phase)
                0: if (en_a && !m_prev) begin m_phase <= 1; m_t <= 0; end
                1: if (m_t == W * P - 1) begin m_phase <= 2; m_last <= 6'(W - 1); end
                   else m_t <= m_t + 1;
                2: if (!en_a) m_phase <= 0;
                default: ;
            endcase
        end
    end

    // Returns {tx, busy, done, rd, addr}.
    function automatic logic [9:0] model_out(input int phase, input int t, input logic [5:0] last);
        int w, r, k, b;
        logic [7:0] byt;
        logic txv;
        if (phase == 0) return {1'b1, 1'b0, 1'b0, 1'b0, last};
        if (phase == 2) return {1'b1, 1'b0, 1'b1, 1'b0, last};
        w = t / P;
        r = t % P;
        txv = 1'b1;
        if (r >= 2) begin
            k = r - 2;
            b = (k % (10 * C)) / C;
            byt = (k < 10 * C) ? mem_a[w][15:8] : mem_a[w][7:0];
            if (b == 0) txv = 1'b0;
            else if (b <= 8) txv = byt[b-1];
        end
        return {txv, 1'b1, 1'b0, (r == 0), 6'(w)};
    endfunction

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e = model_out(m_phase, m_t, m_last);
                checks++;
                if ({tx_a, busy_a, done_a, rd_a, addr_a} !== e) begin
                    errors++;
                    $display("FAIL cycle_model @%0t: got tx=%b busy=%b done=%b rd=%b addr=%0d, want tx=%b busy=%b done=%b rd=%b addr=%0d",
                             $time, tx_a, busy_a, done_a, rd_a, addr_a, e[9], e[8], e[7], e[6], e[5:0]);
                end
            end
        end
    end

    // UART receiver on DUT A, sampling mid-bit.
    logic [7:0] rx_q [$];
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (!rst && tx_a == 1'b0) begin
                repeat (C + C/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    v[i] = tx_a;
                    if (i < 7) repeat (C) @(negedge clk);
                end
                repeat (C) @(negedge clk);
                rx_q.push_back(v);
            end
        end
    end

    int         busy_cnt;
    logic [5:0] rd_log [$];
    logic [5:0] rd_log_b [$];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy_a) busy_cnt++;
                if (rd_a) rd_log.push_back(addr_a);
            end
            if (!rst_b && rd_b) rd_log_b.push_back(addr_b);
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        rd_log.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_done_a(input int bound);
        int n = 0;
        while (!done_a && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done_a, 1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_byte_count"}, rx_q.size(), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            check({tag, "_byte"}, rx_q[i], exp_bytes[i]);
        check({tag, "_busy_cycles"}, busy_cnt, W * P);
        check({tag, "_read_count"}, rd_log.size(), W);
        for (int i = 0; i < W && i < rd_log.size(); i++)
            check({tag, "_read_addr"}, rd_log[i], i);
    endtask

    task automatic run_dump_a(input string tag, input bit frame_chk, input bit toggle);
        logic s [41];
        logic [7:0] v;
        int lo, hi, stable, n;
        clear_logs();
        @(negedge clk);
        en_a = 1'b1;
        if (frame_chk) begin
            n = 0;
            while (tx_a !== 1'b0 && n < 20) begin @(negedge clk); n++; end
            check("first_start_seen", tx_a, 0);
            s[0] = tx_a;
            for (int i = 1; i < 41; i++) begin @(negedge clk); s[i] = tx_a; end
            lo = 0;
            for (int i = 0; i < C; i++) if (s[i] == 1'b0) lo++;
            check("start_bit_len", lo, C);
            stable = 1;
            for (int b = 0; b < 8; b++) begin
                v[b] = s[C + C*b];
                for (int j = 1; j < C; j++) if (s[C + C*b + j] != v[b]) stable = 0;
            end
            check("frame0_data", v, 8'h12);
            check("frame0_bits_stable", stable, 1);
            hi = 0;
            for (int i = 9*C; i < 10*C; i++) if (s[i] == 1'b1) hi++;
            check("stop_bit_len", hi, C);
            check("low_frame_back_to_back", s[10*C], 0);
        end
        if (toggle) begin
            repeat (50) @(negedge clk); en_a = 1'b0;
            repeat (7)  @(negedge clk); en_a = 1'b1;
            repeat (30) @(negedge clk); en_a = 1'b0;
            repeat (3)  @(negedge clk); en_a = 1'b1;
        end
        wait_done_a(W * P + 20);
        check_stream(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_tx", tx_a, 1);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_rd", rd_a, 0);
        check("reset_addr", addr_a, 0);
        rst = 1'b0;
        rst_b = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        check("idle_no_read", rd_log.size(), 0);
        check("idle_busy", busy_a, 0);

        // Basic dump with first-frame timing.
        run_dump_a("dump1", 1'b1, 1'b0);

        // Level held high after done must not start another dump.
        repeat (60) @(negedge clk);
        check("held_high_done", done_a, 1);
        check("held_high_no_redump", rd_log.size(), W);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        check("done_clears", done_a, 0);
        run_dump_a("dump2", 1'b0, 1'b0);

        // Enable toggling mid-dump is ignored.
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        run_dump_a("toggle", 1'b0, 1'b1);

        // Reset during data bit 3 of the high byte of word 2.
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        clear_logs();
        en_a = 1'b1;
        n = 0;
        while (!(rd_a && addr_a == 6'd2) && n < 400) begin @(negedge clk); n++; end
        check("word2_fetch_seen", rd_a && addr_a == 6'd2, 1);
        repeat (2 + 4*C + C/2 - 1) @(negedge clk);
        check("pre_reset_tx", tx_a, 0);
        check("pre_reset_busy", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_tx", tx_a, 1);
        check("async_reset_busy", busy_a, 0);
        check("async_reset_rd", rd_a, 0);
        check("async_reset_addr", addr_a, 0);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (10) @(negedge clk);
        check("post_reset_idle_busy", busy_a, 0);
        check("post_reset_idle_reads", rd_log.size(), 0);
        repeat (50) @(negedge clk);

        // Enable already high when reset releases starts a dump.
        rst = 1'b1;
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        wait_done_a(W * P + 20);
        check_stream("reset_release");
        en_a = 1'b0;

        // 64-word instance.
        @(negedge clk);
        rd_log_b.delete();
        en_b = 1'b1;
        n = 0;
        while (!rd_b && n < 5) begin @(negedge clk); n++; end
        check("b_start", rd_b, 1);
        n = 0;
        while (!done_b && n < WB * P + 100) begin @(negedge clk); n++; end
        check("b_done_cycles", n, WB * P);
        repeat (20) @(negedge clk);
        check("b_read_count", rd_log_b.size(), WB);
        n = 0;
        for (int i = 0; i < rd_log_b.size(); i++) if (rd_log_b[i] != 6'(i)) n++;
        check("b_addr_sequence_errors", n, 0);
        if (rd_log_b.size() > 0) check("b_last_addr", rd_log_b[rd_log_b.size()-1], 63);
        check("b_busy_after", busy_b, 0);
        check("b_tx_idle", tx_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dump_uart_tx.md
RAM_DUMP_UART_TX -- requirements
Module: ram_dump_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2 or more.
REQ-002 Parameter WORDS, default 64, number of RAM words dumped starting at address 0.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable_ram_read  input  1  CPU-finished flag; a rising edge starts a dump.
REQ-006 data_from_ram  input  16  RAM read data, valid the cycle after read_enable_to_ram is asserted.
REQ-007 address_to_ram  output  6  RAM word address being read.
REQ-008 read_enable_to_ram  output  1  one-cycle RAM read strobe.
REQ-009 tx  output  1  UART serial line, 8N1, idle high.
REQ-010 busy  output  1  high from start trigger until the last stop bit ends.
REQ-011 done  output  1  high after a completed dump until enable_ram_read falls.

Function
REQ-012 The block SHALL be a UART transmitter and RAM reader that reads back, as 8N1 bytes, the RAM the CPU wrote.
REQ-013 FSM states SHALL be IDLE, FETCH, CAPTURE, START, DATA, STOP and DONE.
REQ-014 IDLE -> FETCH SHALL occur on the cycle after enable_ram_read is sampled 0 then 1; a level held high SHALL NOT retrigger.
REQ-015 FETCH SHALL last 1 cycle, with read_enable_to_ram=1 and address_to_ram=current word address.
REQ-016 CAPTURE SHALL last 1 cycle and latch data_from_ram into a 16-bit shift word.
REQ-017 Each word SHALL be sent as two frames: high byte [15:8] first, then low byte [7:0].
REQ-018 Each frame SHALL consist of a start bit (0), 8 data bits LSB first, and a stop bit (1), with each bit held exactly CLKS_PER_BIT cycles.
REQ-019 Frames of one word SHALL be back-to-back, with the low-byte start bit on the cycle after the high-byte stop bit ends.
REQ-020 After the low-byte stop bit, if address = WORDS-1 the FSM SHALL go to DONE, else increment the address and go to FETCH.
REQ-021 Per-word time SHALL be exactly 2 + 20*CLKS_PER_BIT cycles.
REQ-022 The address counter SHALL be 6 bits and SHALL NOT wrap past WORDS-1 during a dump.
REQ-023 enable_ram_read falling mid-dump SHALL be ignored, and the dump SHALL run to completion.
REQ-024 A rising edge of enable_ram_read during a dump SHALL be ignored and SHALL NOT queue a second dump.
REQ-025 In DONE, done=1, busy=0 and tx=1.
REQ-026 The FSM SHALL leave DONE for IDLE when enable_ram_read=0.
REQ-027 read_enable_to_ram SHALL be 0 in every state except FETCH.
REQ-028 address_to_ram SHALL hold its value outside FETCH.
REQ-029 tx SHALL be driven from a register, with no combinational glitches.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, tx=1, busy=0, done=0, read_enable_to_ram=0, address_to_ram=0, baud and bit counters=0, and the edge-detect register=0.
REQ-031 Reset mid-frame SHALL abort the frame, with tx returning high asynchronously.
REQ-032 If enable_ram_read is already high when reset deasserts, a dump SHALL start, because the edge register is cleared to 0.

Verification (CLKS_PER_BIT=4, WORDS=4 unless noted)
REQ-033 Scenario: RAM model with words 0x1234,0xABCD,0x00FF,0x8001 and 1-cycle read latency; raise enable_ram_read -> tx bytes 12,34,AB,CD,00,FF,80,01, busy high for 4*(2+80)=328 cycles, then done=1.
REQ-034 Scenario: first frame bit timing -> start bit low for exactly 4 cycles, then bits of 0x12 LSB first (0,1,0,0,1,0,0,0), then stop high for 4 cycles.
REQ-035 Scenario: enable_ram_read held high after done -> no second dump; drop it and raise it again -> an identical second dump, starting from address 0.
REQ-036 Scenario: assert reset during the data bit 3 of word 2 -> tx=1 and busy=0 in the same cycle; after release with enable low, the FSM stays IDLE.
REQ-037 Scenario: toggle enable_ram_read low/high mid-dump -> the byte stream is unchanged, only 8 bytes are sent, and read_enable_to_ram pulses exactly 4 times at addresses 0,1,2,3.
REQ-038 Scenario: WORDS=64 -> the last read is at address 63, there is no read at address 0 after it, and done asserts after 64*82 cycles.
